// File: rtl/game_pkg.sv
// Playfield geometry and ball state encoding shared by the ball and paddle blocks.
package game_pkg;

    localparam int unsigned ScreenW  = 640;
    localparam int unsigned ScreenH  = 480;
    localparam int unsigned BallSize = 8;
    localparam int unsigned PaddleW  = 64;
    localparam int unsigned PaddleY  = 440;
    localparam int unsigned TickDiv  = 250000;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StMiss
    } ball_state_e;

endpackage

// File: rtl/tick_divider.sv
// Modulo-Div step counter; tick is high during the last count of each period.
module tick_divider #(
    parameter int unsigned Div = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Breakout ball physics: serve from the paddle, wall/paddle reflection, miss detection.
module ball_motion
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_W  = ScreenW,
    parameter int unsigned SCREEN_H  = ScreenH,
    parameter int unsigned BALL_SIZE = BallSize,
    parameter int unsigned PADDLE_W  = PaddleW,
    parameter int unsigned PADDLE_Y  = PaddleY,
    parameter int unsigned TICK_DIV  = TickDiv
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_active,
    output logic       hit,
    output logic       miss
);

    localparam logic [10:0] XMax    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] YMax    = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] YRest   = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] SnapOff = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] XReset  = 11'(SCREEN_W / 2 - BALL_SIZE / 2);

    ball_state_e state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic        dx_left_q, dx_left_d;  // 1: dx = -1
    logic        dy_up_q, dy_up_d;      // 1: dy = -1
    logic        active_q, active_d, hit_q, hit_d, miss_q, miss_d;
    logic        step, div_clear;
    logic [10:0] snap_x, bx, px;
    logic        overlap;

    tick_divider #(
        .Div(TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .enable((state_q == StMoving) && !pause),
        .clear (div_clear),
        .tick  (step)
    );

    assign bx      = {1'b0, ball_x_q};
    assign px      = {1'b0, paddle_x};
    assign snap_x  = px + SnapOff;
    assign overlap = (bx + 11'(BALL_SIZE) > px) && (bx < px + 11'(PADDLE_W));

    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        dx_left_d = dx_left_q;
        dy_up_d   = dy_up_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        div_clear = 1'b0;
        if (!pause) begin
            unique case (state_q)
                StIdle: begin
                    ball_x_d = snap_x[9:0];
                    ball_y_d = YRest[9:0];
                    if (launch) begin
                        state_d   = StMoving;
                        dx_left_d = 1'b0;
                        dy_up_d   = 1'b1;
                        div_clear = 1'b1;
                    end
                end
                StMoving: begin
                    if (step) begin
                        if (dy_up_q && ball_y_q == 10'd0) begin
                            dy_up_d  = 1'b0;
                            ball_y_d = 10'd1;
                        end else if (!dy_up_q && {1'b0, ball_y_q} == YRest && overlap) begin
                            dy_up_d  = 1'b1;
                            ball_y_d = ball_y_q - 10'd1;
                            hit_d    = 1'b1;
                        end else if (!dy_up_q && {1'b0, ball_y_q} == YMax) begin
                            miss_d  = 1'b1;
                            state_d = StMiss;
                        end else begin
                            ball_y_d = dy_up_q ? ball_y_q - 10'd1 : ball_y_q + 10'd1;
                        end
                        // A miss freezes the ball where it left the playfield.
                        if (!miss_d) begin
                            if (dx_left_q && ball_x_q == 10'd0) begin
                                dx_left_d = 1'b0;
                                ball_x_d  = 10'd1;
                            end else if (!dx_left_q && bx == XMax) begin
                                dx_left_d = 1'b1;
                                ball_x_d  = ball_x_q - 10'd1;
                            end else begin
                                ball_x_d = dx_left_q ? ball_x_q - 10'd1 : ball_x_q + 10'd1;
                            end
                        end
                    end
                end
                StMiss: begin
                    state_d   = StIdle;
                    ball_x_d  = snap_x[9:0];
                    ball_y_d  = YRest[9:0];
                    dx_left_d = 1'b0;
                    dy_up_d   = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
        active_d = (state_d == StMoving);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ball_x_q  <= XReset[9:0];
            ball_y_q  <= YRest[9:0];
            dx_left_q <= 1'b0;
            dy_up_q   <= 1'b1;
            active_q  <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            dx_left_q <= dx_left_d;
            dy_up_q   <= dy_up_d;
            active_q  <= active_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign ball_active = active_q;
    assign hit         = hit_q;
    assign miss        = miss_q;

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball physics engine for the breakout playfield: owns the ball position and direction, reads the paddle's `x_pos` each cycle to resolve paddle collisions, and reports hits and misses to the score/lives logic. It sits beside the paddle block in the game core, consumes the same `pause` and screen geometry, and feeds the renderer with the ball position.

## Interface
- `SCREEN_W`, 640, playfield width in pixels.
- `SCREEN_H`, 480, playfield height in pixels.
- `BALL_SIZE`, 8, square ball edge length in pixels.
- `PADDLE_W`, 64, paddle width in pixels.
- `PADDLE_Y`, 440, top row of the paddle.
- `TICK_DIV`, 250000, clk cycles per one-pixel ball step (minimum 2).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `pause`  in  1  freezes all state, including the divider.
- `launch`  in  1  serve request; honoured only in IDLE.
- `paddle_x`  in  10  paddle left edge; 0..SCREEN_W-PADDLE_W.
- `ball_x`  out  10  ball left edge.
- `ball_y`  out  10  ball top edge.
- `ball_active`  out  1  high in MOVING.
- `hit`  out  1  one-cycle pulse on paddle bounce.
- `miss`  out  1  one-cycle pulse when the ball reaches the bottom.

## Operation
- States: IDLE, MOVING, MISS. Reset -> IDLE.
- IDLE: every cycle, `ball_x <= paddle_x + PADDLE_W/2 - BALL_SIZE/2`; `ball_y <= PADDLE_Y - BALL_SIZE`. `launch && !pause` -> MOVING with dx=+1, dy=-1, divider cleared.
- MOVING: the divider counts 0..TICK_DIV-1; a step fires when the count is TICK_DIV-1. Each step resolves x and y independently:
  - x with dx=-1 at `ball_x==0`: dx becomes +1, `ball_x` becomes 1.
  - x with dx=+1 at `ball_x==SCREEN_W-BALL_SIZE`: dx becomes -1, `ball_x` decrements.
  - otherwise `ball_x` moves by dx.
  - y with dy=-1 at `ball_y==0`: dy becomes +1, `ball_y` becomes 1.
  - y with dy=+1 at `ball_y+BALL_SIZE==PADDLE_Y` and overlap: dy becomes -1, `ball_y` decrements, and `hit` pulses. Overlap is `ball_x+BALL_SIZE > paddle_x && ball_x < paddle_x+PADDLE_W`.
  - y with dy=+1 at `ball_y==SCREEN_H-BALL_SIZE`: `miss` pulses and the state goes to MISS; position is held.
  - otherwise `ball_y` moves by dy.
- Overlap uses the current `paddle_x` sample at the step cycle.
- Corner cases, such as wall plus top or wall plus paddle, reflect both axes in the same step.
- MISS: lasts exactly one cycle, then IDLE. The ball re-snaps to the paddle on the next cycle.
- `launch` outside IDLE is ignored.
- `pause` high: state, position, direction and divider are all held. `hit` and `miss` cannot fire. In IDLE the ball does not track the paddle.
- Reset mid-flight: immediate return to the IDLE reset values.
- All sums use 11-bit intermediates, so `paddle_x+PADDLE_W` cannot wrap.

## Timing
- Reset values:
  - state IDLE, divider 0, dx=+1, dy=-1.
  - `ball_x = SCREEN_W/2 - BALL_SIZE/2` (316).
  - `ball_y = PADDLE_Y - BALL_SIZE` (432).
  - `ball_active`, `hit` and `miss` are 0.
- IDLE tracking latency: 1 cycle from `paddle_x` to `ball_x`.
- Launch accepted at edge N: `ball_active` is high after N. The first step updates position at edge N+TICK_DIV.
- `hit` and `miss` are registered and high for exactly the cycle following the step edge. `ball_active` falls on the same edge that `miss` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `game_pkg` holds:
  - the screen, ball and paddle geometry constants, shared with the paddle block;
  - the ball state enum (IDLE/MOVING/MISS).
- Sub-module `tick_divider`: parameterised modulo-TICK_DIV counter with `enable` (MOVING && !pause), sync `clear`, and a one-cycle `tick` output.
- Collision and reflection logic stays flat in `ball_motion`.

## Test plan
- Reset with `paddle_x=288`: `ball_x=316`, `ball_y=432`, `ball_active=0`. Then drive `paddle_x=100` -> `ball_x=128` one cycle later.
- TICK_DIV=4, `paddle_x=288`, `launch` pulse: `ball_active=1`; 4 cycles later position is (317,431); after 8 cycles it is (318,430).
- `paddle_x=576` (ball 604), launch: after 28 steps `ball_x=632`. The next step gives dx=-1, `ball_x=631`, `ball_y=403`.
- Paddle hit: after the top bounce, hold the paddle under the descending ball. At `ball_y=432` the step pulses `hit`, sets dy=-1 and gives `ball_y=431`.
- Miss: move the paddle out from under the ball -> the ball passes y=432 and reaches 472. The next step pulses `miss` for one cycle, `ball_active` drops, and the ball re-snaps to the paddle; a `launch` held during MOVING had no effect.
- Pause for 20 cycles mid-flight: position, divider and direction are unchanged. Release resumes the step exactly TICK_DIV minus the elapsed count later. Reset asserted mid-flight returns the block to the reset values asynchronously.
